rv32m_iter_divider: RTL and testbench
=====================================

Name: rv32m_iter_divider

Overview:
- Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside the single-cycle ALU and multiplier in the execute stage.
- The pipeline stalls on `busy`, and a pending interrupt or flush aborts an in-flight divide through `cancel`.
- Results and corner cases follow the RISC-V M-extension rules exactly.

Parameters:
- XLEN, 32, operand/result width (only 32 is supported).
- CNT_W, 6, width of the iteration counter (must hold XLEN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  input  32  dividend (rs1), sampled with start.
- b  input  32  divisor (rs2), sampled with start.
- cancel  input  1  abort (interrupt/flush); highest priority after rst.
- busy  output  1  high from the cycle after an accepted start until ready.
- ready  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  32  quotient or remainder; held until the next ready.

Behaviour:
- One clock domain (`clk`). Reset is synchronous, active-high (`rst`).
- Reset values: state=IDLE, busy=0, ready=0, result=0, all internal registers 0.
- Reset mid-operation: identical to power-on reset; no ready is produced.

States:
- IDLE:
  - start=1 latches op, a, b.
  - If b==0 or (signed op and a==32'h8000_0000 and b==32'hFFFF_FFFF), go to SPECIAL.
  - Otherwise go to RUN with count=0.
  - start=0 stays in IDLE.
- SPECIAL (1 cycle), sets result, then goes to DONE:
  - b==0: DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> a.
  - Overflow: DIV -> 32'h8000_0000; REM -> 0.
- RUN (exactly 32 cycles, count 0..31):
  - Shift {rem,quo} left by 1.
  - Trial = rem - |b|, computed 33 bits wide.
  - Non-negative trial: rem=trial, quo[0]=1. Negative trial: restore, quo[0]=0.
  - After count==31, go to FIX.
- FIX (1 cycle):
  - Signed ops only: quotient negated if a[31]^b[31]; remainder negated if a[31].
  - Selects quotient (op[1]=0) or remainder (op[1]=1) into result, then goes to DONE.
- DONE (1 cycle): ready=1, busy=0, then goes to IDLE.
  - start in DONE is ignored; the requester must wait for IDLE.

Operand handling:
- Signed operands use magnitudes; |0x8000_0000| = 0x8000_0000 as unsigned.

Latency (start sampled at edge 0):
- Normal: busy=1 in cycles 1..33, ready=1 in cycle 34.
- Special: busy=1 in cycle 1, ready=1 in cycle 2.

Handshake and priority:
- start while busy or in DONE is ignored and does not corrupt operands.
- cancel in SPECIAL/RUN/FIX: next state IDLE, busy=0, no ready pulse, result keeps its previous value.
- cancel in DONE: the ready pulse still completes this cycle.
- cancel and start together in IDLE: cancel wins, start is dropped.
- Priority: rst > cancel > state logic.
- busy and ready are never high in the same cycle.

Test Plan:
- DIVU a=100, b=7 -> ready in cycle 34, result=14; busy high exactly 33 cycles.
- REM a=-7 (0xFFFF_FFF9), b=2 -> result=0xFFFF_FFFF (-1). DIV with the same operands -> 0xFFFF_FFFD (-3).
- Divide by zero: DIV a=5, b=0 -> 0xFFFF_FFFF. REMU a=5, b=0 -> 5. Both ready in cycle 2.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM -> 0. DIVU with the same operands -> 0 (normal 34-cycle path).
- cancel asserted in RUN cycle 10 -> busy low the next cycle, no ready. A following start DIVU 9/3 -> result 3 in cycle 34, with no stale state.
- rst mid-RUN, and start pulses during busy: outputs return to reset values, and ignored starts do not change the in-flight result. Random sign/magnitude sweep vs. a reference model for all four ops.

Source files
------------

// File: rtl/rv32m_iter_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and overflow short-circuit.
module rv32m_iter_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {
    IDLE, SPECIAL, RUN, FIX, DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN-1);

  state_t           state;
  logic [1:0]       op_r;
  logic [XLEN-1:0]  a_r;
  logic [XLEN-1:0]  b_r;
  logic [XLEN-1:0]  dvs;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  quo;
  logic [CNT_W-1:0] count;

  logic            sgn_in;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            special_in;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            trial_neg;
  logic            sgn_r;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    sgn_in = ~op[0];
    a_mag = (sgn_in & a[XLEN-1]) ? -a : a;
    b_mag = (sgn_in & b[XLEN-1]) ? -b : b;
    special_in = (b == '0) ||
                 (sgn_in && a == MIN && b == ONES);
  end

  // Partial remainder can reach 2*|b|-1, so the trial needs a spare bit.
  always_comb begin
    shifted   = {rem, quo[XLEN-1]};
    diff      = {1'b0, shifted} - {2'b00, dvs};
    trial_neg = diff[XLEN+1];
  end

  always_comb begin
    sgn_r = ~op_r[0];
    q_fix = (sgn_r & (a_r[XLEN-1] ^ b_r[XLEN-1])) ? -quo : quo;
    r_fix = (sgn_r & a_r[XLEN-1]) ? -rem : rem;
    if (b_r == '0)
      spec_res = op_r[1] ? a_r : ONES;
    else
      spec_res = op_r[1] ? '0 : MIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      ready  <= 1'b0;
      result <= '0;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      dvs    <= '0;
      rem    <= '0;
      quo    <= '0;
      count  <= '0;
    end else if (cancel) begin
      state <= IDLE;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            dvs   <= b_mag;
            rem   <= '0;
            quo   <= a_mag;
            count <= '0;
            busy  <= 1'b1;
            state <= special_in ? SPECIAL : RUN;
          end
        end
        SPECIAL: begin
          result <= spec_res;
          busy   <= 1'b0;
          ready  <= 1'b1;
          state  <= DONE;
        end
        RUN: begin
          rem   <= trial_neg ? shifted[XLEN-1:0] : diff[XLEN-1:0];
          quo   <= {quo[XLEN-2:0], ~trial_neg};
          count <= count + CNT_W'(1);
          if (count == LAST)
            state <= FIX;
        end
        FIX: begin
          result <= op_r[1] ? r_fix : q_fix;
          busy   <= 1'b0;
          ready  <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_iter_divider.sv
// Scoreboard bench for rv32m_iter_divider.
// Stimulus pushes expected results; a monitor pops them on ready.
module tb_rv32m_iter_divider;

  localparam logic [31:0] MIN = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        ready;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  rv32m_iter_divider #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .cancel(cancel), .busy(busy),
    .ready(ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // RISC-V M-extension rules; SV / and % truncate toward zero.
  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = x;
    sy = y;
    if (y == 0) return o[1] ? x : ONES;
    if (!o[0]) begin
      if (x == MIN && y == ONES) return o[1] ? 32'h0 : MIN;
      return o[1] ? 32'(sx % sy) : 32'(sx / sy);
    end
    return o[1] ? x % y : x / y;
  endfunction

  function automatic int lat_of(input logic [1:0] o,
                                input logic [31:0] x,
                                input logic [31:0] y);
    if (y == 0 || (!o[0] && x == MIN && y == ONES)) return 2;
    return 34;
  endfunction

  // Monitor: every ready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && ready) chk("busy_and_ready", 32'(busy & ready), 32'h0);
      if (ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 32'h1, 32'h0);
        end else begin
          chk("result", result, exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit noise);
    int cyc;
    int busy_n;
    int lat;
    bit got;
    lat = lat_of(o, x, y);
    exp_q.push_back(model(o, x, y));
    last_exp = model(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_n = 0; got = 1'b0;
    while (!got && cyc <= 60) begin
      if (ready) begin
        got = 1'b1;
      end else begin
        if (busy) busy_n++;
        @(negedge clk);
        cyc++;
        start = noise && (cyc == 5 || cyc == 20 || cyc == lat);
        if (start) begin
          op = 2'($urandom); a = $urandom; b = $urandom;
        end
      end
    end
    start = 1'b0;
    chk("ready_seen", 32'(got), 32'h1);
    chk("latency", 32'(cyc), 32'(lat));
    chk("busy_cycles", 32'(busy_n), 32'(lat - 1));
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return MIN;
      2: return ONES;
      3: return 32'($urandom_range(1, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_cycles_no_ready(input int n, input string name);
    int rdy;
    rdy = 0;
    repeat (n) begin
      @(negedge clk);
      if (ready) rdy++;
    end
    chk(name, 32'(rdy), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_result", result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b01, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b00, 32'd5, 32'd0, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 1'b0);
    run_op(2'b00, MIN, ONES, 1'b0);
    run_op(2'b10, MIN, ONES, 1'b0);
    run_op(2'b01, MIN, ONES, 1'b0);
    run_op(2'b01, ONES, 32'd1, 1'b1);

    // Cancel in RUN cycle 10.
    start = 1'b1; op = 2'b01; a = $urandom; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 32'h0);
    wait_cycles_no_ready(40, "cancel_no_ready");
    chk("cancel_result_held", result, last_exp);
    run_op(2'b01, 32'd9, 32'd3, 1'b0);

    // Cancel in SPECIAL.
    start = 1'b1; op = 2'b00; a = 32'd8; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_special_busy", 32'(busy), 32'h0);
    wait_cycles_no_ready(5, "cancel_special_no_ready");
    chk("cancel_special_held", result, last_exp);

    // Cancel together with start in IDLE.
    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", 32'(busy), 32'h0);
    wait_cycles_no_ready(40, "cancel_start_no_ready");

    // Reset mid-RUN.
    start = 1'b1; op = 2'b00; a = $urandom; b = 32'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_ready", 32'(ready), 32'h0);
    chk("midrst_result", result, 32'h0);
    wait_cycles_no_ready(40, "midrst_no_ready");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = pick();
      y = pick();
      run_op(2'($urandom), x, y, i[0]);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
